// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit:
// FSM state encoding, operation codes, iteration counts and a magnitude helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [5:0] MUL_ITER = 6'd16;
  localparam logic [5:0] DIV_ITER = 6'd32;

  // Absolute value of a 32-bit two's-complement number, read as unsigned.
  // The most negative value maps onto itself, which is its correct magnitude
  // when interpreted as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier group {b[2i+1], b[2i], b[2i-1]}
// onto partial-product selects. The digit is zero, or +/-1x, or +/-2x of the
// multiplicand.
module booth_r4_enc (
  input  logic [2:0] grp,
  output logic       zero,
  output logic       neg,
  output logic       two
);

  // Decode the group into zero / negate / double selects.
  always_comb begin
    zero = 1'b0;
    neg  = 1'b0;
    two  = 1'b0;
    case (grp)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: neg  = 1'b0;
      3'b011:         two  = 1'b1;
      3'b100: begin
        neg = 1'b1;
        two = 1'b1;
      end
      3'b101, 3'b110: neg  = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply / divide unit.
// Multiply: radix-4 Booth, 16 cycles, {hi,lo} = 64-bit product.
// Divide: 32-cycle non-restoring on magnitudes plus one fix-up cycle,
// lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  // Architectural state.
  state_t           state_r, state_nxt_s;
  logic [WIDTH+1:0] acc_r, acc_nxt_s;      // product high part / partial remainder
  logic [WIDTH-1:0] mq_r, mq_nxt_s;        // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] mcand_r, mcand_nxt_s;  // multiplicand / divisor magnitude
  logic             prev_r, prev_nxt_s;    // Booth b[-1] bit carried between groups
  logic [5:0]       cnt_r, cnt_nxt_s;      // shared iteration counter
  logic             a_neg_r, a_neg_nxt_s;
  logic             b_neg_r, b_neg_nxt_s;
  logic [WIDTH-1:0] hi_r, hi_nxt_s;
  logic [WIDTH-1:0] lo_r, lo_nxt_s;
  logic             div_zero_r, div_zero_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;

  // Datapath helpers.
  logic [2:0]       grp_s;
  logic             zero_s, neg_s, two_s;
  logic [WIDTH+1:0] mag_s, pp_s, mul_sum_s;
  logic [WIDTH+1:0] div_shift_s, div_sum_s;
  logic [WIDTH-1:0] rem_s;

  assign grp_s = {mq_r[1:0], prev_r};

  booth_r4_enc u_enc (
    .grp  (grp_s),
    .zero (zero_s),
    .neg  (neg_s),
    .two  (two_s)
  );

  // Booth partial product, sign-extended to the accumulator width.
  always_comb begin
    if (two_s) begin
      mag_s = {mcand_r[WIDTH-1], mcand_r, 1'b0};
    end else begin
      mag_s = {{2{mcand_r[WIDTH-1]}}, mcand_r};
    end
    if (zero_s) begin
      pp_s = '0;
    end else if (neg_s) begin
      pp_s = '0 - mag_s;
    end else begin
      pp_s = mag_s;
    end
    mul_sum_s = acc_r + pp_s;
  end

  // One non-restoring divide step and the final remainder restore.
  always_comb begin
    div_shift_s = {acc_r[WIDTH:0], mq_r[WIDTH-1]};
    if (acc_r[WIDTH+1]) begin
      div_sum_s = div_shift_s + {2'b00, mcand_r};
    end else begin
      div_sum_s = div_shift_s - {2'b00, mcand_r};
    end
    if (acc_r[WIDTH+1]) begin
      rem_s = acc_r[WIDTH-1:0] + mcand_r;
    end else begin
      rem_s = acc_r[WIDTH-1:0];
    end
  end

  // Next-state and next-register values for the whole FSM.
  always_comb begin
    state_nxt_s    = state_r;
    acc_nxt_s      = acc_r;
    mq_nxt_s       = mq_r;
    mcand_nxt_s    = mcand_r;
    prev_nxt_s     = prev_r;
    cnt_nxt_s      = cnt_r;
    a_neg_nxt_s    = a_neg_r;
    b_neg_nxt_s    = b_neg_r;
    hi_nxt_s       = hi_r;
    lo_nxt_s       = lo_r;
    div_zero_nxt_s = div_zero_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          cnt_nxt_s      = 6'd0;
          acc_nxt_s      = '0;
          prev_nxt_s     = 1'b0;
          div_zero_nxt_s = 1'b0;
          a_neg_nxt_s    = a[WIDTH-1];
          b_neg_nxt_s    = b[WIDTH-1];
          if (op == OP_MUL) begin
            state_nxt_s = MUL;
            mcand_nxt_s = a;
            mq_nxt_s    = b;
          end else if (b == {WIDTH{1'b0}}) begin
            // Divide by zero short-circuits straight to completion.
            state_nxt_s    = DONE;
            hi_nxt_s       = a;
            lo_nxt_s       = {WIDTH{1'b1}};
            div_zero_nxt_s = 1'b1;
          end else begin
            state_nxt_s = DIV;
            mcand_nxt_s = mag32(b);
            mq_nxt_s    = mag32(a);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      MUL: begin
        // Arithmetic shift of {acc, mq} right by one bit pair after the add.
        acc_nxt_s  = {{2{mul_sum_s[WIDTH+1]}}, mul_sum_s[WIDTH+1:2]};
        mq_nxt_s   = {mul_sum_s[1:0], mq_r[WIDTH-1:2]};
        prev_nxt_s = mq_r[1];
        cnt_nxt_s  = cnt_r + 6'd1;
        if (cnt_r == MUL_ITER - 6'd1) begin
          state_nxt_s = DONE;
          hi_nxt_s    = acc_nxt_s[WIDTH-1:0];
          lo_nxt_s    = mq_nxt_s;
        end else begin
          state_nxt_s = MUL;
        end
      end

      DIV: begin
        acc_nxt_s = div_sum_s;
        mq_nxt_s  = {mq_r[WIDTH-2:0], ~div_sum_s[WIDTH+1]};
        cnt_nxt_s = cnt_r + 6'd1;
        if (cnt_r == DIV_ITER - 6'd1) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = DIV;
        end
      end

      FIX: begin
        state_nxt_s = DONE;
        if (a_neg_r) begin
          hi_nxt_s = {WIDTH{1'b0}} - rem_s;
        end else begin
          hi_nxt_s = rem_s;
        end
        if (a_neg_r ^ b_neg_r) begin
          lo_nxt_s = {WIDTH{1'b0}} - mq_r;
        end else begin
          lo_nxt_s = mq_r;
        end
      end

      DONE: begin
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == MUL) || (state_nxt_s == DIV) || (state_nxt_s == FIX);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r      <= '0;
      mq_r       <= '0;
      mcand_r    <= '0;
      prev_r     <= 1'b0;
      cnt_r      <= 6'd0;
      a_neg_r    <= 1'b0;
      b_neg_r    <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      acc_r      <= acc_nxt_s;
      mq_r       <= mq_nxt_s;
      mcand_r    <= mcand_nxt_s;
      prev_r     <= prev_nxt_s;
      cnt_r      <= cnt_nxt_s;
      a_neg_r    <= a_neg_nxt_s;
      b_neg_r    <= b_neg_nxt_s;
      hi_r       <= hi_nxt_s;
      lo_r       <= lo_nxt_s;
      div_zero_r <= div_zero_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a cycle-level behavioural model (plain 64-bit
// arithmetic plus latency counts) checked every cycle, directed corner cases
// with literal expectations, and a randomized stimulus phase.
module tb_muldiv_seq;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  // Reference result computed with 64-bit signed arithmetic.
  function automatic res_t ref_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    res_t   r;
    longint sx, sy, p, q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r.dz = 1'b0;
    if (o == 1'b0) begin
      p = sx * sy;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (sy == 0) begin
      r.dz = 1'b1;
      r.hi = x;
      r.lo = 32'hFFFF_FFFF;
    end else begin
      q = sx / sy;
      m = sx % sy;
      r.hi = m[31:0];
      r.lo = q[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model state.
  res_t cur_res;
  res_t pend = '0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic exp_dz = 1'b0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  int   m_left = 0;

  assign cur_res = ref_op(op, a, b);

  // Model: acceptance rules and latencies, result from plain arithmetic.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_dz   <= 1'b0;
      exp_hi   <= 32'd0;
      exp_lo   <= 32'd0;
      m_left   <= 0;
    end else begin
      exp_done <= 1'b0;
      if (exp_busy) begin
        if (m_left == 1) begin
          exp_busy <= 1'b0;
          exp_done <= 1'b1;
          exp_hi   <= pend.hi;
          exp_lo   <= pend.lo;
          exp_dz   <= pend.dz;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (!exp_done && start) begin
        if (op == 1'b1 && b == 32'd0) begin
          exp_done <= 1'b1;
          exp_hi   <= cur_res.hi;
          exp_lo   <= cur_res.lo;
          exp_dz   <= cur_res.dz;
        end else begin
          exp_busy <= 1'b1;
          exp_dz   <= 1'b0;
          m_left   <= (op == 1'b1) ? 33 : 16;
          pend     <= cur_res;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clock) begin
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("div_zero", div_zero, exp_dz);
    if (!exp_busy) begin
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  // Issue one operation from IDLE and measure cycles from the start cycle to done.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 1'($urandom_range(0, 1));
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int   lat;
    int   guard;
    res_t r;

    // Reset.
    #1 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // Pin the model with hand-computed values.
    r = ref_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("pin_mul", {r.hi, r.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    r = ref_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("pin_mul_min", {r.hi, r.lo}, 64'h4000_0000_0000_0000);
    r = ref_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("pin_div", {r.hi, r.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    r = ref_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("pin_div_wrap", {r.dz, r.hi, r.lo}, {1'b0, 64'h0000_0000_8000_0000});
    r = ref_op(1'b1, 32'd5, 32'd0);
    chk("pin_div0", {r.dz, r.hi, r.lo}, {1'b1, 64'h0000_0005_FFFF_FFFF});

    // Multiply 7 * -3.
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat);
    chk("mul_lat", lat, 17);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFEB);
    step();

    // Multiply most-negative squared.
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat);
    chk("mulmin_hi", hi, 32'h4000_0000);
    chk("mulmin_lo", lo, 32'h0000_0000);
    step();

    // Divide -7 / 2.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", lat, 34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step();

    // Divide by zero.
    run_op(1'b1, 32'd5, 32'd0, lat);
    chk("div0_lat", lat, 1);
    chk("div0_dz", div_zero, 1'b1);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    step();

    // Most-negative / -1 wraps without a flag.
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("wrap_lo", lo, 32'h8000_0000);
    chk("wrap_hi", hi, 32'd0);
    chk("wrap_dz", div_zero, 1'b0);
    step();

    // Start pulsed mid-multiply with other operands is ignored.
    op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    op = 1'b1; a = 32'd100; b = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      step();
      guard++;
    end
    chk("ign_done", done, 1'b1);
    chk("ign_lo", lo, 32'd15);
    chk("ign_hi", hi, 32'd0);
    chk("ign_dz", div_zero, 1'b0);
    step();

    // Reset in the middle of a divide.
    op = 1'b1; a = 32'd1000; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    guard = 0;
    repeat (30) begin
      step();
      if (done) guard++;
    end
    chk("midrst_nodone", guard, 0);
    run_op(1'b0, 32'd6, 32'd7, lat);
    chk("post_rst_lat", lat, 17);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);
    step();

    // Randomized traffic; inputs and start change every cycle.
    repeat (4000) begin
      start = ($urandom_range(0, 3) == 0);
      op = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      step();
    end
    start = 1'b0;
    guard = 0;
    while ((busy || done) && guard < 60) begin
      step();
      guard++;
    end
    chk("drain", {busy, done}, 2'b00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
